fifo_mac_consumer: RTL and testbench
====================================

# fifo_mac_consumer

Downstream consumer for a pair of operand FIFOs (A and B) of the FIFO block's kind, which have registered read data valid one cycle after a qualified read. On a `start` pulse the block pops exactly LEN operand pairs, multiplies each pair as unsigned integers and accumulates the products into `acc`. It stalls whenever either FIFO is empty, and signals completion with a one-cycle `done` pulse. It sits between the operand FIFOs and the result/status logic of the minilab datapath.

## Interface
- DATA_WIDTH, 8, operand width; must match the FIFO DATA_WIDTH.
- LEN, 8, operand pairs consumed per run; LEN >= 1.
- ACC_WIDTH, 24, accumulator width; sums wrap modulo 2^ACC_WIDTH.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- a_empty  in  1  FIFO A empty flag.
- b_empty  in  1  FIFO B empty flag.
- a_data  in  DATA_WIDTH  FIFO A registered read data.
- b_data  in  DATA_WIDTH  FIFO B registered read data.
- a_rden  out  1  FIFO A read enable (combinational).
- b_rden  out  1  FIFO B read enable (combinational); always equal to a_rden.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse (DONE state).
- acc  out  ACC_WIDTH  accumulated sum; holds its value after done until the next accepted start.

## Operation
- States:
  - IDLE: start=1 -> clear acc, issue_cnt and acc_cnt to 0; go to RUN.
  - RUN: issue_cnt reaches LEN on this edge -> go to DRAIN.
  - DRAIN: the final accumulation (acc_cnt reaches LEN) occurs on this edge -> go to DONE.
  - DONE: one cycle only; go to IDLE.
- Read issue: a_rden = b_rden = rst_n & (state==RUN) & !a_empty & !b_empty & (issue_cnt < LEN).
  - Both FIFOs are always popped together; a read is never issued while either FIFO is empty.
- issue_cnt increments on every edge where rden=1.
- Pipeline:
  - rd_v <= rden.
  - When rd_v: prod <= a_data * b_data (2*DATA_WIDTH, unsigned); prod_v <= rd_v.
  - When prod_v: acc <= acc + zero-extended prod (truncated to ACC_WIDTH); acc_cnt increments.
- a_data/b_data are sampled only when rd_v=1; stale FIFO output values are ignored.
- Bubbles from empty stalls propagate as rd_v/prod_v = 0; acc is unchanged on those cycles.
- start is ignored in RUN, DRAIN and DONE. The next start is accepted in IDLE, the cycle after done.
- Counter widths: $clog2(LEN+1).

## Timing
- Reset: a_rden=0, b_rden=0, busy=0, done=0, acc=0, state=IDLE, all counters and valid bits 0.
  - rden is held 0 whenever rst_n=0, including a reset asserted mid-run. No further reads are issued until a new start.
- start sampled at edge E with both FIFOs never empty:
  - rden is high for the LEN cycles following E.
  - The last accumulation and the DONE entry both occur at edge E+LEN+2.
  - done is high for exactly the cycle after E+LEN+2, with the final acc valid in that cycle.
- Each empty-stall cycle adds one cycle to done latency.
- Throughput: one pair per cycle.
- Read-to-accumulate latency: 3 edges (rden cycle -> data -> prod -> acc).
- If a FIFO becomes empty mid-run, rden drops in that same cycle, because it is combinational from the empty flags.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, rden 0 even with both FIFOs non-empty.
- Basic run (LEN=4): A={1,2,3,4}, B={5,6,7,8} preloaded, start at edge E -> rden high for exactly 4 consecutive cycles; done high one cycle after E+6; acc=70; busy low afterwards.
- Stall: B empty at start, then B={5,6,7,8} written one word every 3 cycles -> rden never asserted while a_empty or b_empty is 1; exactly 4 pops from each FIFO; acc=70; done once.
- Width/wrap: A=B={255,255,255,255} -> acc=260100 (0x3F804) with ACC_WIDTH=24; acc=63492 with ACC_WIDTH=16.
- Restart/ignore: pulse start during RUN -> no effect. After done, start with A={1,1,1,1}, B={2,2,2,2} -> acc cleared, then acc=8.
- Reset mid-run: assert rst_n=0 after 2 pops -> next edge acc=0, busy=0, done=0; rden stays 0 while in reset and until a new start. A fresh run then gives the correct sum on the remaining FIFO contents.

Source files
------------

// File: rtl/fifo_mac_consumer.sv
// Pops LEN operand pairs from two lock-stepped FIFOs, multiplies each pair and
// accumulates the products; one-cycle done pulse at the end of a run.
module fifo_mac_consumer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN        = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  acc
);

  // state | meaning
  // IDLE  | waiting for start; acc holds the last result
  // RUN   | issuing reads while both FIFOs have data
  // DRAIN | all reads issued, waiting for the pipeline to accumulate
  // DONE  | one-cycle completion pulse
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [1:0]              state;
  logic [CNT_W-1:0]        issue_cnt;
  logic [CNT_W-1:0]        acc_cnt;
  logic                    rd_v;
  logic                    prod_v;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    rden;

  // rst_n gates the read strobe so a mid-run reset stops popping immediately.
  assign rden   = rst_n & (state == RUN) & ~a_empty & ~b_empty & (issue_cnt < LEN_C);
  assign a_rden = rden;
  assign b_rden = rden;
  assign busy   = (state == RUN) | (state == DRAIN);
  assign done   = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      rd_v      <= 1'b0;
      prod_v    <= 1'b0;
      prod      <= '0;
      acc       <= '0;
    end else begin
      rd_v   <= rden;
      prod_v <= rd_v;
      if (rd_v)
        prod <= {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
      if (rden)
        issue_cnt <= issue_cnt + ONE;
      if (prod_v) begin
        acc     <= acc + ACC_WIDTH'(prod);
        acc_cnt <= acc_cnt + ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rden && (issue_cnt == LEN_M1))
            state <= DRAIN;
        end
        DRAIN: begin
          if (prod_v && (acc_cnt == LEN_M1))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mac_consumer.sv
// Table-driven bench for fifo_mac_consumer (LEN=4) with a behavioural FIFO pair;
// a second 16-bit-accumulator instance shares the FIFOs to check wrap-around.
module tb_fifo_mac_consumer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a_empty, b_empty;
  logic [7:0] a_data, b_data;
  logic       a_rden, b_rden, busy, done;
  logic [23:0] acc;
  logic       a_rden2, b_rden2, busy2, done2;
  logic [15:0] acc2;

  always #5 clk = ~clk;

  fifo_mac_consumer #(.DATA_WIDTH(8), .LEN(4), .ACC_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a_rden), .b_rden(b_rden),
    .busy(busy), .done(done), .acc(acc));

  fifo_mac_consumer #(.DATA_WIDTH(8), .LEN(4), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a_rden2), .b_rden(b_rden2),
    .busy(busy2), .done(done2), .acc(acc2));

  // FIFO pair with registered read data; stale output is randomised.
  logic [7:0] a_mem [256];
  logic [7:0] b_mem [256];
  int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
  assign a_empty = (a_wr == a_rd);
  assign b_empty = (b_wr == b_rd);

  always @(posedge clk) begin
    if (a_rden) begin
      a_data <= a_mem[a_rd[7:0]];
      a_rd   <= a_rd + 1;
    end else
      a_data <= 8'($urandom);
    if (b_rden) begin
      b_data <= b_mem[b_rd[7:0]];
      b_rd   <= b_rd + 1;
    end else
      b_data <= 8'($urandom);
  end

  int tests = 0, fails = 0;
  int viol = 0, neq = 0;

  always @(negedge clk) begin
    if (a_rden && (a_empty || b_empty)) viol++;
    if ((a_rden !== b_rden) || (a_rden !== a_rden2) || (a_rden !== b_rden2)) neq++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] d);
    a_mem[a_wr[7:0]] = d;
    a_wr = a_wr + 1;
  endtask

  task automatic push_b(input logic [7:0] d);
    b_mem[b_wr[7:0]] = d;
    b_wr = b_wr + 1;
  endtask

  typedef struct {
    logic [31:0] a;      // byte 0 is popped first
    logic [31:0] b;
    int          exp24;
    int          exp16;
    bit          poke;   // pulse start while RUN
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input bit load, input string nm);
    int a0, b0, done_k, ndone, rcyc, acc_at, acc16_at;
    if (load)
      for (int j = 0; j < 4; j++) begin
        push_a(v.a[8*j +: 8]);
        push_b(v.b[8*j +: 8]);
      end
    a0 = a_rd; b0 = b_rd;
    done_k = -1; ndone = 0; rcyc = 0; acc_at = -1; acc16_at = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_rden_first"}, a_rden, 1);
    for (int k = 0; k < 30; k++) begin
      if (a_rden) rcyc++;
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k   = k;
          acc_at   = int'(acc);
          acc16_at = int'(acc2);
        end
      end
      start = (v.poke && (k == 2 || k == 5)) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    chk({nm, "_done_latency"}, done_k, 6);
    chk({nm, "_done_count"}, ndone, 1);
    chk({nm, "_rden_cycles"}, rcyc, 4);
    chk({nm, "_acc"}, acc_at, v.exp24);
    chk({nm, "_acc16"}, acc16_at, v.exp16);
    chk({nm, "_pops_a"}, a_rd - a0, 4);
    chk({nm, "_pops_b"}, b_rd - b0, 4);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_acc_hold"}, acc, v.exp24);
  endtask

  initial begin
    int a0, b0, ndone, acc_at, pushed;
    vec_t v;

    vecs[0] = '{32'h04030201, 32'h08070605,     70,    70, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 260100, 63492, 1'b0};
    vecs[2] = '{32'h01010101, 32'h02020202,      8,     8, 1'b1};
    vecs[3] = '{32'h281E140A, 32'h03030303,    300,   300, 1'b0};
    vecs[4] = '{32'h00000000, 32'h09090909,      0,     0, 1'b0};
    vecs[5] = '{32'h193264C8, 32'h193264C8,  53125, 53125, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      push_a(vecs[0].a[8*j +: 8]);
      push_b(vecs[0].b[8*j +: 8]);
    end
    step();
    step();
    chk("rst_a_rden", a_rden, 0);
    chk("rst_b_rden", b_rden, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc", acc, 0);
    chk("rst_acc16", acc2, 0);
    rst_n = 1'b1;
    step();
    chk("idle_rden", a_rden, 0);

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], i != 0, $sformatf("vec%0d", i));

    // B starts empty and is fed one word every third cycle
    for (int j = 0; j < 4; j++) push_a(8'(j + 1));
    a0 = a_rd; b0 = b_rd; ndone = 0; acc_at = -1; pushed = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("stall_rden_blocked", a_rden, 0);
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        ndone++;
        acc_at = int'(acc);
      end
      if ((k % 3 == 2) && pushed < 4) begin
        push_b(8'(pushed + 5));
        pushed++;
      end
      step();
    end
    chk("stall_done_count", ndone, 1);
    chk("stall_acc", acc_at, 70);
    chk("stall_pops_a", a_rd - a0, 4);
    chk("stall_pops_b", b_rd - b0, 4);

    // reset asserted after two pops
    for (int j = 0; j < 6; j++) begin
      push_a(8'(j + 1));
      push_b(8'd2);
    end
    a0 = a_rd;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rden_now", a_rden, 0);
    chk("mid_rst_pops", a_rd - a0, 2);
    step();
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rden", a_rden, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rden0", a_rden, 0);
    step();
    step();
    chk("post_rst_rden1", a_rden, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pops", a_rd - a0, 2);
    v = '{32'h0, 32'h0, 36, 36, 1'b0};
    run_vec(v, 1'b0, "after_rst");

    chk("rden_while_empty", viol, 0);
    chk("rden_mismatch", neq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
